// File: rtl/tile_eoc_monitor.sv
// tile_eoc_monitor
// Watches the L2 simulation memory write-monitor stream. It detects the
// end-of-computation write and latches the exit code. It captures putchar
// writes into a small FIFO. It runs a watchdog while a program is running.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   mon_w_valid_i         one observed write beat this cycle
//   mon_w_addr_i          byte address of the beat
//   mon_w_data_i          write data of the beat
//   arm_i                 start-of-run pulse (IDLE -> RUN)
//   clear_i               return to IDLE and clear run status
//   state_o               00 IDLE, 01 RUN, 10 DONE, 11 TIMEOUT
//   eoc_o, timeout_o      high in DONE / TIMEOUT
//   exit_code_o           exit code latched from the EOC write
//   run_cycles_o          cycles spent in RUN (saturating)
//   stdout_valid_o        FIFO head holds a character
//   stdout_char_o         FIFO head character
//   stdout_ready_i        consumer accepts the head
//   stdout_overflow_o     sticky: a character was dropped
//   stdout_drops_o        saturating count of dropped characters
//
// Stdout handshake: a character transfers on a cycle where stdout_valid_o
// and stdout_ready_i are both high. stdout_valid_o never depends on
// stdout_ready_i. Once stdout_valid_o is high, it and stdout_char_o stay
// stable until that transfer happens.
module tile_eoc_monitor #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] EOC_ADDR       = 32'h2C03_0000,
  parameter logic [ADDR_W-1:0] STDOUT_ADDR    = 32'h2C03_0004,
  parameter int                FIFO_DEPTH     = 16,
  parameter logic [31:0]       TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mon_w_valid_i,
  input  logic [ADDR_W-1:0] mon_w_addr_i,
  input  logic [DATA_W-1:0] mon_w_data_i,
  input  logic              arm_i,
  input  logic              clear_i,
  output logic [1:0]        state_o,
  output logic              eoc_o,
  output logic              timeout_o,
  output logic [31:0]       exit_code_o,
  output logic [31:0]       run_cycles_o,
  output logic              stdout_valid_o,
  output logic [7:0]        stdout_char_o,
  input  logic              stdout_ready_i,
  output logic              stdout_overflow_o,
  output logic [15:0]       stdout_drops_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_DONE    = 2'b10,
    ST_TIMEOUT = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] run_cycles_q, run_cycles_d;
  logic [31:0] exit_code_q, exit_code_d;

  // Lane select: a 64-bit bus carries two 32-bit words, and address bit 2
  // picks the upper one. Zero-extending to 64 bits keeps one expression
  // legal for both widths.
  logic [63:0] data_ext;
  logic [31:0] lane;
  logic        eoc_hit, std_hit, wd_expire;
  logic [1:0]  unused_addr_lsb;

  assign data_ext        = 64'(mon_w_data_i);
  assign lane            = (DATA_W == 64 && mon_w_addr_i[2]) ? data_ext[63:32] : data_ext[31:0];
  assign eoc_hit         = mon_w_valid_i && (mon_w_addr_i[ADDR_W-1:2] == EOC_ADDR[ADDR_W-1:2]);
  assign std_hit         = mon_w_valid_i && (mon_w_addr_i[ADDR_W-1:2] == STDOUT_ADDR[ADDR_W-1:2]);
  assign wd_expire       = (TIMEOUT_CYCLES != 32'd0) && (run_cycles_q == TIMEOUT_CYCLES - 32'd1);
  assign unused_addr_lsb = mon_w_addr_i[1:0];

  // ---------------- run-control FSM ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      run_cycles_q <= 32'd0;
      exit_code_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      run_cycles_q <= run_cycles_d;
      exit_code_q  <= exit_code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    run_cycles_d = run_cycles_q;
    exit_code_d  = exit_code_q;
    if (clear_i) begin
      state_d      = ST_IDLE;
      run_cycles_d = 32'd0;
      exit_code_d  = 32'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // An EOC beat in the arming cycle is ignored.
          if (arm_i) begin
            state_d      = ST_RUN;
            run_cycles_d = 32'd0;
          end
        end
        ST_RUN: begin
          // The counter freezes on the leaving edge, so it keeps the last
          // RUN value.
          if (eoc_hit && lane != 32'd0) begin
            state_d     = ST_DONE;
            exit_code_d = lane;
          end else if (wd_expire) begin
            state_d = ST_TIMEOUT;
          end else if (run_cycles_q != 32'hFFFF_FFFF) begin
            run_cycles_d = run_cycles_q + 32'd1;
          end
        end
        default: ; // DONE and TIMEOUT hold until clear_i
      endcase
    end
  end

  assign state_o      = state_q;
  assign eoc_o        = (state_q == ST_DONE);
  assign timeout_o    = (state_q == ST_TIMEOUT);
  assign exit_code_o  = exit_code_q;
  assign run_cycles_o = run_cycles_q;

  // ---------------- stdout FIFO ----------------
  logic [7:0]     mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_q, rd_q, wr_d, rd_d;
  logic           valid_q, valid_d;
  logic [7:0]     head_q, head_d;
  logic           full, pop, push_ok, drop;
  logic           ovf_q;
  logic [15:0]    drops_q;

  assign full    = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign pop     = valid_q && stdout_ready_i;
  assign push_ok = std_hit && (!full || pop);
  assign drop    = std_hit && !push_ok;
  assign rd_d    = rd_q + {{PTR_W{1'b0}}, pop};
  assign wr_d    = wr_q + {{PTR_W{1'b0}}, push_ok};
  assign valid_d = (wr_d != rd_d);

  // Head is registered. When the FIFO is empty after this cycle's pop, the
  // slot being written now becomes the next head. Storage does not have it
  // yet, so take the character straight from the bus.
  assign head_d = (push_ok && wr_q == rd_d) ? lane[7:0] : mem[rd_d[PTR_W-1:0]];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_q[PTR_W-1:0]] <= lane[7:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
      head_q  <= 8'd0;
      ovf_q   <= 1'b0;
      drops_q <= 16'd0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      if (clear_i) begin
        ovf_q   <= 1'b0;
        drops_q <= 16'd0;
      end else if (drop) begin
        ovf_q <= 1'b1;
        if (drops_q != 16'hFFFF) drops_q <= drops_q + 16'd1;
      end
    end
  end

  assign stdout_valid_o    = valid_q;
  assign stdout_char_o     = head_q;
  assign stdout_overflow_o = ovf_q;
  assign stdout_drops_o    = drops_q;

endmodule

// File: tb/tb_tile_eoc_monitor.sv
// Bench for tile_eoc_monitor. It drives two instances from the same beats:
// index 0 has a 32-bit data bus and index 1 has a 64-bit data bus. Both use a
// 4-entry FIFO and a 100-cycle watchdog. A transaction-level model predicts
// every output at each falling edge.
module tb_tile_eoc_monitor;

  localparam logic [31:0] EOC_A = 32'h2C03_0000;
  localparam logic [31:0] STD_A = 32'h2C03_0004;
  localparam int          DEPTH = 4;
  localparam int          TMO   = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mon_valid = 1'b0;
  logic [31:0] mon_addr = '0;
  logic [31:0] dhi = '0, dlo = '0;
  logic        arm_s = 1'b0, clr_s = 1'b0, rdy = 1'b0;

  logic [1:0]  o_state [2];
  logic        o_eoc [2], o_to [2], o_valid [2], o_ovf [2];
  logic [31:0] o_exit [2], o_cyc [2];
  logic [7:0]  o_char [2];
  logic [15:0] o_drops [2];

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  tile_eoc_monitor #(.ADDR_W(32), .DATA_W(32), .EOC_ADDR(EOC_A), .STDOUT_ADDR(STD_A),
                     .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) u32 (
    .clk_i(clk), .rst_i(rst), .mon_w_valid_i(mon_valid), .mon_w_addr_i(mon_addr),
    .mon_w_data_i(dlo), .arm_i(arm_s), .clear_i(clr_s),
    .state_o(o_state[0]), .eoc_o(o_eoc[0]), .timeout_o(o_to[0]), .exit_code_o(o_exit[0]),
    .run_cycles_o(o_cyc[0]), .stdout_valid_o(o_valid[0]), .stdout_char_o(o_char[0]),
    .stdout_ready_i(rdy), .stdout_overflow_o(o_ovf[0]), .stdout_drops_o(o_drops[0]));

  tile_eoc_monitor #(.ADDR_W(32), .DATA_W(64), .EOC_ADDR(EOC_A), .STDOUT_ADDR(STD_A),
                     .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) u64 (
    .clk_i(clk), .rst_i(rst), .mon_w_valid_i(mon_valid), .mon_w_addr_i(mon_addr),
    .mon_w_data_i({dhi, dlo}), .arm_i(arm_s), .clear_i(clr_s),
    .state_o(o_state[1]), .eoc_o(o_eoc[1]), .timeout_o(o_to[1]), .exit_code_o(o_exit[1]),
    .run_cycles_o(o_cyc[1]), .stdout_valid_o(o_valid[1]), .stdout_char_o(o_char[1]),
    .stdout_ready_i(rdy), .stdout_overflow_o(o_ovf[1]), .stdout_drops_o(o_drops[1]));

  // ---------------- reference model ----------------
  // Status codes: 0 idle, 1 run, 2 done, 3 timeout.
  int          m_state [2];
  logic [31:0] m_exit [2], m_cyc [2];
  bit          m_ovf [2];
  logic [15:0] m_drops [2];
  logic [7:0]  exp_q0[$];
  logic [7:0]  exp_q1[$];

  function automatic int q_size(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [7:0] q_head(input int i);
    return (i == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  task automatic q_pop(input int i);
    if (i == 0) void'(exp_q0.pop_front());
    else        void'(exp_q1.pop_front());
  endtask

  task automatic q_push(input int i, input logic [7:0] c);
    if (i == 0) exp_q0.push_back(c);
    else        exp_q1.push_back(c);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; m_exit[i] = 0; m_cyc[i] = 0; m_ovf[i] = 0; m_drops[i] = 0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // Apply the current inputs to instance i's model, as the next edge will.
  task automatic model_step(input int i);
    logic [31:0] lane;
    bit eh, sh, pop;
    lane = (i == 1 && mon_addr[2]) ? dhi : dlo;
    eh   = mon_valid && ((mon_addr >> 2) == (EOC_A >> 2));
    sh   = mon_valid && ((mon_addr >> 2) == (STD_A >> 2));
    pop  = rdy && (q_size(i) > 0);
    if (clr_s) begin
      m_state[i] = 0; m_exit[i] = 0; m_cyc[i] = 0; m_ovf[i] = 0; m_drops[i] = 0;
    end else if (m_state[i] == 0) begin
      if (arm_s) begin m_state[i] = 1; m_cyc[i] = 0; end
    end else if (m_state[i] == 1) begin
      if (eh && lane != 0) begin m_state[i] = 2; m_exit[i] = lane; end
      else if (m_cyc[i] == TMO - 1) m_state[i] = 3;
      else if (m_cyc[i] != 32'hFFFF_FFFF) m_cyc[i] = m_cyc[i] + 1;
    end
    if (pop) q_pop(i);
    if (sh) begin
      if (q_size(i) < DEPTH) q_push(i, lane[7:0]);
      else if (!clr_s) begin
        m_ovf[i] = 1;
        if (m_drops[i] != 16'hFFFF) m_drops[i] = m_drops[i] + 1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("state%0d", i),   32'(o_state[i]), 32'(m_state[i]));
      check_eq($sformatf("eoc%0d", i),     32'(o_eoc[i]),   32'(m_state[i] == 2));
      check_eq($sformatf("timeout%0d", i), 32'(o_to[i]),    32'(m_state[i] == 3));
      check_eq($sformatf("exit%0d", i),    o_exit[i],       m_exit[i]);
      check_eq($sformatf("cycles%0d", i),  o_cyc[i],        m_cyc[i]);
      check_eq($sformatf("svalid%0d", i),  32'(o_valid[i]), 32'(q_size(i) > 0));
      if (q_size(i) > 0) check_eq($sformatf("schar%0d", i), 32'(o_char[i]), 32'(q_head(i)));
      check_eq($sformatf("ovf%0d", i),     32'(o_ovf[i]),   32'(m_ovf[i]));
      check_eq($sformatf("drops%0d", i),   32'(o_drops[i]), 32'(m_drops[i]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] hi,
                       input logic [31:0] lo, input bit arm, input bit clr);
    mon_valid = v; mon_addr = a; dhi = hi; dlo = lo; arm_s = arm; clr_s = clr;
    cycle();
    mon_valid = 0; arm_s = 0; clr_s = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 32'h0, 0, 0, 0, 0);
  endtask

  task automatic putc(input logic [7:0] c);
    drive(1, STD_A, {24'h0, c}, {24'h0, c}, 0, 0);
  endtask

  task automatic drain();
    rdy = 1; idle(DEPTH + 2); rdy = 0;
  endtask

  logic [7:0] hello [5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
  int n;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    check_outputs();
    check_eq("rst_char0", 32'(o_char[0]), 0);
    check_eq("rst_char1", 32'(o_char[1]), 0);

    // Zero exit code is ignored; a nonzero one ends the run.
    drive(0, 0, 0, 0, 1, 0);
    idle(50);
    drive(1, EOC_A, 0, 32'h0, 0, 0);
    check_eq("zero_eoc_run", 32'(o_state[0]), 1);
    drive(1, EOC_A, 0, 32'h2A, 0, 0);
    check_eq("done_state", 32'(o_state[0]), 2);
    check_eq("exit42", o_exit[0], 42);
    idle(3);
    check_eq("rc_frozen", o_cyc[0], 51);

    // Watchdog: timeout exactly 100 cycles after arming.
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 0);
    n = 0;
    while (!o_to[0] && n < 150) begin idle(1); n++; end
    check_eq("to_latency", n, 100);
    check_eq("to_cycles", o_cyc[0], 99);
    drive(1, EOC_A, 0, 32'h5, 0, 0);
    check_eq("to_sticky", 32'(o_state[0]), 3);

    // EOC in the watchdog expiry cycle wins; clear beats a same-cycle EOC.
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 0);
    idle(99);
    check_eq("pre_expiry", o_cyc[0], 99);
    drive(1, EOC_A, 0, 32'h7, 0, 0);
    check_eq("eoc_beats_to", 32'(o_state[0]), 2);
    drive(1, EOC_A, 0, 32'h9, 0, 1);
    check_eq("clr_idle", 32'(o_state[0]), 0);
    check_eq("clr_exit", o_exit[0], 0);

    // Arm in IDLE ignores a same-cycle EOC beat.
    drive(1, EOC_A, 32'h3, 32'h3, 1, 0);
    check_eq("arm_over_eoc", 32'(o_state[0]), 1);
    drive(0, 0, 0, 0, 0, 1);

    // "Hello" into a 4-deep FIFO: 'o' is dropped, then "Hell" is read out in order.
    drain();
    for (int k = 0; k < 5; k++) putc(hello[k]);
    check_eq("hello_ovf", 32'(o_ovf[0]), 1);
    check_eq("hello_drops", 32'(o_drops[0]), 1);
    rdy = 1;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("hell%0d", k), 32'(o_char[0]), 32'(hello[k]));
      idle(1);
    end
    check_eq("hell_empty", 32'(o_valid[0]), 0);
    rdy = 0;

    // Full FIFO with a push and a pop in the same cycle: nothing is dropped.
    drive(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) putc(8'h30 + 8'(k));
    rdy = 1;
    putc(8'h5A);
    rdy = 0;
    check_eq("fullpp_drops", 32'(o_drops[0]), 0);
    check_eq("fullpp_head", 32'(o_char[0]), 32'h31);
    rdy = 1;
    n = 0;
    while (o_valid[0] && n < 10) begin idle(1); n++; end
    check_eq("fullpp_occ", n, 4);
    rdy = 0;

    // 64-bit lanes: upper lane stdout, upper-lane-only EOC data, async reset.
    putc(8'h00);
    drain();
    drive(1, STD_A, 32'h0000_0041, $urandom, 0, 0);
    check_eq("lane64_A", 32'(o_char[1]), 32'h41);
    drain();
    drive(0, 0, 0, 0, 1, 0);
    drive(1, EOC_A, 32'h55, 32'h0, 0, 0);
    check_eq("upper_eoc_ignored", 32'(o_state[1]), 1);
    idle(5);
    #2 rst = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("arst_state%0d", i), 32'(o_state[i]), 0);
      check_eq($sformatf("arst_cyc%0d", i),   o_cyc[i], 0);
      check_eq($sformatf("arst_exit%0d", i),  o_exit[i], 0);
      check_eq($sformatf("arst_valid%0d", i), 32'(o_valid[i]), 0);
      check_eq($sformatf("arst_char%0d", i),  32'(o_char[i]), 0);
      check_eq($sformatf("arst_drops%0d", i), 32'(o_drops[i]), 0);
    end
    @(negedge clk);
    rst = 0;
    model_reset();
    check_outputs();

    // Random traffic checked against the model every cycle.
    for (int k = 0; k < 2000; k++) begin
      logic [31:0] a, lo;
      case ($urandom_range(0, 3))
        0: a = EOC_A;
        1: a = STD_A;
        2: a = 32'h2C03_0008;
        default: a = $urandom;
      endcase
      lo  = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom_range(1, 255);
      rdy = $urandom_range(0, 1);
      drive($urandom_range(0, 1), a, $urandom_range(0, 255), lo,
            $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
